// File: rtl/b220068cs_sneha_3_pkg.sv
// Shared types and constants for the combination-lock controller.
// Contents: lock state enum, 3-bit code type, NO_ENTRY constant, progress width.
package lock_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned PROG_W = 2;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [PROG_W-1:0] prog_t;

  localparam code_t NO_ENTRY = 3'd0;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    ALARM    = 2'd2
  } lock_state_t;

endpackage

// File: rtl/b220068cs_sneha_3_relock_timer.sv
// Loadable down-counter that times how long the lock stays open.
// Ports: clk, rst (async active-high), load (load start value), en (count down),
//        done_c (combinational: the next enabled decrement reaches zero).
module relock_timer #(
  parameter int unsigned START = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done_c
);

  localparam int unsigned TW = $clog2(START + 1);

  logic [TW-1:0] count;

  // Load takes priority; the counter parks at zero once expired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= TW'(START);
    end else if (en && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign done_c = en && (count == TW'(1));

endmodule

// File: rtl/b220068cs_sneha_3.sv
// Sequential combination-lock controller with auto-relock and sticky alarm.
// Ports: sw (3-bit code entry, 0 = none), clk, reset (async active-high),
//        alarm (in ALARM), locked (low only while UNLOCKED),
//        entimer (relock timer running), selsw (index of next expected entry).
module b220068cs_sneha_3
  import lock_pkg::*;
#(
  parameter code_t       CODE0         = 3'd1,
  parameter code_t       CODE1         = 3'd2,
  parameter code_t       CODE2         = 3'd3,
  parameter code_t       CODE3         = 3'd4,
  parameter int unsigned UNLOCK_CYCLES = 8
) (
  input  logic [2:0] sw,
  input  logic       clk,
  input  logic       reset,
  output logic       alarm,
  output logic       locked,
  output logic       entimer,
  output logic [1:0] selsw
);

  lock_state_t state, state_n;
  prog_t       p, p_n;
  code_t       sw_prev;
  logic        event_c;
  logic        load_c;
  logic        en_c;
  logic        done_c;
  code_t       expected_c;
  logic        locked_n, alarm_n, entimer_n;
  logic [1:0]  selsw_n;

  relock_timer #(.START(UNLOCK_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (reset),
    .load   (load_c),
    .en     (en_c),
    .done_c (done_c)
  );

  // A new, non-zero value on sw is one entry; holding or returning to 0 is not.
  assign event_c = (sw != sw_prev) && (sw != NO_ENTRY);

  // Code entry expected at the current progress position.
  always_comb begin
    expected_c = CODE0;
    case (p)
      2'd0:    expected_c = CODE0;
      2'd1:    expected_c = CODE1;
      2'd2:    expected_c = CODE2;
      default: expected_c = CODE3;
    endcase
  end

  // State register, progress, entry history and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= LOCKED;
      p       <= '0;
      sw_prev <= NO_ENTRY;
      locked  <= 1'b1;
      alarm   <= 1'b0;
      entimer <= 1'b0;
      selsw   <= 2'd0;
    end else begin
      state   <= state_n;
      p       <= p_n;
      sw_prev <= sw;
      locked  <= locked_n;
      alarm   <= alarm_n;
      entimer <= entimer_n;
      selsw   <= selsw_n;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_n   = state;
    p_n       = p;
    load_c    = 1'b0;
    en_c      = 1'b0;
    locked_n  = 1'b1;
    alarm_n   = 1'b0;
    entimer_n = 1'b0;
    selsw_n   = 2'd0;

    case (state)
      LOCKED: begin
        if (event_c) begin
          if (sw == expected_c) begin
            if (p == prog_t'(3)) begin
              state_n = UNLOCKED;
              p_n     = '0;
              load_c  = 1'b1;
            end else begin
              p_n = p + prog_t'(1);
            end
          end else begin
            state_n = ALARM;
            p_n     = '0;
          end
        end
      end
      UNLOCKED: begin
        // Entries are ignored while open; the relock edge does not evaluate sw.
        en_c = 1'b1;
        if (done_c) begin
          state_n = LOCKED;
          p_n     = '0;
        end
      end
      ALARM: begin
        state_n = ALARM;
      end
      default: begin
        state_n = LOCKED;
        p_n     = '0;
      end
    endcase

    case (state_n)
      UNLOCKED: begin
        locked_n  = 1'b0;
        entimer_n = 1'b1;
      end
      ALARM: begin
        alarm_n = 1'b1;
      end
      default: begin
        selsw_n = 2'(p_n);
      end
    endcase
  end

endmodule

// File: tb/tb_b220068cs_sneha_3.sv
// Self-checking bench for the combination-lock controller: directed steps from
// the test plan followed by randomized entries against a behavioural model.
module tb_b220068cs_sneha_3;

  localparam int UC = 8;

  logic [2:0] sw;
  logic       clk;
  logic       reset;
  logic       alarm;
  logic       locked;
  logic       entimer;
  logic [1:0] selsw;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 = locked, 1 = unlocked, 2 = alarm.
  logic [2:0] codes [4];
  int         m_mode;
  int         m_p;
  int         m_left;
  logic [2:0] m_prev;

  b220068cs_sneha_3 #(
    .CODE0(3'd1), .CODE1(3'd2), .CODE2(3'd3), .CODE3(3'd4), .UNLOCK_CYCLES(UC)
  ) dut (
    .sw      (sw),
    .clk     (clk),
    .reset   (reset),
    .alarm   (alarm),
    .locked  (locked),
    .entimer (entimer),
    .selsw   (selsw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_p    = 0;
    m_left = 0;
    m_prev = 3'd0;
  endtask

  // Applies the lock rules for one rising edge with sw = v.
  task automatic model_edge(input logic [2:0] v);
    bit ev;
    ev = (v != m_prev) && (v != 3'd0);
    m_prev = v;
    if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 0;
        m_p    = 0;
      end
    end else if (m_mode == 0 && ev) begin
      if (v == codes[m_p]) begin
        if (m_p == 3) begin
          m_mode = 1;
          m_left = UC;
          m_p    = 0;
        end else begin
          m_p++;
        end
      end else begin
        m_mode = 2;
        m_p    = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".locked"},  {1'b0, locked},  {1'b0, m_mode != 1});
    chk({tag, ".alarm"},   {1'b0, alarm},   {1'b0, m_mode == 2});
    chk({tag, ".entimer"}, {1'b0, entimer}, {1'b0, m_mode == 1});
    chk({tag, ".selsw"},   selsw,           (m_mode == 0) ? 2'(m_p) : 2'd0);
  endtask

  // Drive sw, take one edge, sample 1 time unit later.
  task automatic step(input logic [2:0] v, input string tag);
    sw = v;
    @(posedge clk);
    model_edge(v);
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] v;
    codes[0] = 3'd1; codes[1] = 3'd2; codes[2] = 3'd3; codes[3] = 3'd4;
    sw    = 3'd0;
    reset = 1'b0;
    model_reset();

    // Reset before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk("rst.locked",  {1'b0, locked},  2'd1);
    chk("rst.alarm",   {1'b0, alarm},   2'd0);
    chk("rst.entimer", {1'b0, entimer}, 2'd0);
    chk("rst.selsw",   selsw,           2'd0);
    @(negedge clk);
    reset = 1'b0;

    // Correct sequence.
    step(3'd1, "seq1"); chk("seq1.sel", selsw, 2'd1);
    step(3'd2, "seq2"); chk("seq2.sel", selsw, 2'd2);
    step(3'd3, "seq3"); chk("seq3.sel", selsw, 2'd3);
    step(3'd4, "seq4");
    chk("unlock.locked",  {1'b0, locked},  2'd0);
    chk("unlock.entimer", {1'b0, entimer}, 2'd1);

    // Hold 4: open for exactly UC edges, then relock with no alarm.
    for (int i = 1; i < UC; i++) begin
      step(3'd4, "open");
      chk("open.locked", {1'b0, locked}, 2'd0);
    end
    step(3'd4, "relock");
    chk("relock.locked",  {1'b0, locked},  2'd1);
    chk("relock.entimer", {1'b0, entimer}, 2'd0);
    chk("relock.alarm",   {1'b0, alarm},   2'd0);
    step(3'd4, "relock_hold");
    chk("relock_hold.alarm", {1'b0, alarm}, 2'd0);

    // Wrong entry after relock, alarm stays while sw changes.
    step(3'd6, "wrong");
    chk("wrong.alarm", {1'b0, alarm}, 2'd1);
    step(3'd1, "alarm_a");
    step(3'd2, "alarm_b");
    step(3'd0, "alarm_c");
    chk("alarm_sticky", {1'b0, alarm}, 2'd1);

    // Reset clears alarm; wrong entry 5 alarms again.
    pulse_reset("rst_alarm");
    chk("rst_alarm.alarm", {1'b0, alarm}, 2'd0);
    step(3'd5, "wrong5");
    chk("wrong5.alarm", {1'b0, alarm}, 2'd1);

    // Held entry and zero handling.
    pulse_reset("rst_hold");
    for (int i = 0; i < 5; i++) begin
      step(3'd1, "hold1");
      chk("hold1.sel", selsw, 2'd1);
    end
    step(3'd0, "zero");
    chk("zero.sel", selsw, 2'd1);
    step(3'd1, "repeat1");
    chk("repeat1.alarm", {1'b0, alarm}, 2'd1);

    // Randomized entries, biased towards the correct next code.
    for (int r = 0; r < 25; r++) begin
      pulse_reset("rnd_rst");
      for (int s = 0; s < 40; s++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: v = (m_mode == 0) ? codes[m_p] : 3'($urandom_range(0, 7));
          6:                v = 3'd0;
          7:                v = m_prev;
          default:          v = 3'($urandom_range(0, 7));
        endcase
        if (s == 0 && m_prev == v && v == codes[0]) v = 3'd0;
        step(v, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/b220068cs_sneha_3.md
# b220068cs_sneha_3

Sequential combination-lock controller. It accepts 3-bit code entries on a switch bus and unlocks after the four-entry code sequence is entered correctly. It then runs an auto-relock timer and raises a sticky alarm on any wrong entry. It sits between a switch/keypad front end and the lock actuator and alarm driver.

## Interface
Parameters:
- CODE0, default 3'd1: first code entry.
- CODE1, default 3'd2: second code entry.
- CODE2, default 3'd3: third code entry.
- CODE3, default 3'd4: fourth code entry.
- UNLOCK_CYCLES, default 8: number of clock cycles the lock stays open before auto-relock (must be ≥1).

Ports (positional order in instantiation: sw, clk, reset, alarm, locked, entimer, selsw):
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- sw, input, 3: code entry bus; 3'd0 means "no entry".
- alarm, output, 1: high while in ALARM.
- locked, output, 1: low only while UNLOCKED.
- entimer, output, 1: relock-timer enable, high while UNLOCKED.
- selsw, output, 2: index of the next expected code entry (0–3).

## Operation
- An entry event occurs on a rising edge when sw ≠ sw_prev and sw ≠ 0.
  - sw_prev is sw registered every cycle; its reset value is 0.
  - A held value produces only one event.
  - A return to 0 produces no event.
- States:
  - LOCKED with progress p = 0..3.
  - UNLOCKED.
  - ALARM.
- LOCKED, entry event equal to CODE[p]:
  - p < 3: p ← p+1.
  - p == 3: go to UNLOCKED and load the timer with UNLOCK_CYCLES.
- LOCKED, entry event not equal to CODE[p]: go to ALARM, p ← 0.
- LOCKED, no event: hold state and p.
- UNLOCKED:
  - The timer decrements every cycle; entry events are ignored.
  - When the timer would reach 0, go to LOCKED with p = 0.
- ALARM: sticky; only reset leaves it. Entry events are ignored.
- Output values by state:
  - LOCKED: locked=1, alarm=0, entimer=0, selsw=p.
  - UNLOCKED: locked=0, alarm=0, entimer=1, selsw=0.
  - ALARM: locked=1, alarm=1, entimer=0, selsw=0.

## Timing
- All outputs are registered (Moore). They change only on a rising clk edge or on reset assertion.
- Reset values: state LOCKED, p=0, sw_prev=0, timer=0, locked=1, alarm=0, entimer=0, selsw=0.
- Reset mid-operation immediately returns the block to the reset values, from any state, including clearing ALARM.
- Entry latency: sw sampled at edge N is reflected in the outputs after edge N.
- Unlock: the edge that samples a correct CODE3 sets locked=0 and entimer=1.
- Relock: exactly UNLOCK_CYCLES edges later, locked=1 and entimer=0. The relock edge itself does not evaluate entries.
- An entry value still held on sw after relock is not re-evaluated, because of the sw_prev edge rule.
- Only one entry can occur per cycle, so there are no simultaneous entry events.

## Structure
- Shared package lock_pkg contains:
  - The state enum: LOCKED, UNLOCKED, ALARM.
  - The 3-bit code type.
  - The NO_ENTRY = 3'd0 constant.
- One sub-module is natural: relock_timer. It is a loadable down-counter with a load input, an enable input and a done output, and its width is $clog2(UNLOCK_CYCLES+1).
- The top level holds the FSM, the progress counter, sw_prev and the output registers.

## Test plan
- Reset check: reset pulse with sw=0 → locked=1, alarm=0, entimer=0, selsw=0 immediately, before any clock edge.
- Correct sequence: sw=1, 2, 3, 4, one cycle each → selsw=1, 2, 3 after successive edges, then locked=0 and entimer=1 after the 4th edge.
- Auto-relock: hold sw=4 after unlock → locked=0 for exactly 8 cycles, then locked=1, entimer=0, selsw=0, and no alarm despite sw=4 being held.
- Wrong entry after relock: with the block relocked, sw=6 → alarm=1 and locked=1 after the next edge; alarm stays high while sw changes.
- Reset clears alarm: with the block in ALARM, assert reset, then release it and apply sw=5 → alarm=0 while reset is high, then alarm=1 after the first edge that samples sw=5.
- Held entry and zero handling:
  - sw=1 held for 5 cycles → selsw stays 1 (one event only).
  - sw=0 → no change.
  - sw=1 again → ALARM, because the expected code is 2.
